multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Moore-style sequencing FSM for the multicycle RV32I core. It takes the opcode and function fields latched in the instruction register, walks the shared ALU, register file and unified memory port through fetch, decode, execute, memory and writeback. It emits every datapath select and write-enable for each state. It replaces the single-cycle `control_unit` when the core is built with one memory and one ALU shared across cycles.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  7  instruction[6:0] from IR
- funct3  in  3  instruction[14:12]
- funct7  in  1  instruction[30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC enable
- mem_req  out  1  memory access requested this cycle
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
- ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  out  1  register-file write enable
- instr_done  out  1  one-cycle pulse on each instruction's final cycle
- illegal  out  1  high while halted on an unsupported opcode

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL.
- Transitions:
  - FETCH→DECODE.
  - DECODE: op 0000011/0100011→MEMADR; 0110011→EXECR; 0010011→EXECI; 1100011→BEQ; 1101111→JAL; anything else→ILLEGAL.
  - MEMADR: op[5]=0→MEMREAD, else MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECR/EXECI→ALUWB→FETCH.
  - BEQ→FETCH.
  - JAL→ALUWB.
  - ILLEGAL holds until reset.
- Outputs per state. Any signal not listed is 0. ALUControl defaults to add.
  - FETCH: mem_req, IRWrite, PCWrite, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10. Computes the branch/jump target into ALUOut.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=00 for load, 01 for store.
  - MEMREAD: mem_req, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite.
  - MEMWRITE: mem_req, AdrSrc=1, MemWrite.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALU decode.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALU decode.
  - ALUWB: ResultSrc=00, RegWrite.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUControl=sub, ResultSrc=00, PCWrite=Zero.
  - JAL: ALUSrcA=01, ALUSrcB=10, ImmSrc=11, ResultSrc=00, PCWrite.
  - ILLEGAL: illegal=1.
- ALU decode (EXECR/EXECI only), by funct3:
  - 000: sub if funct7&op[5], else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Other funct3: add. ALUControl is never X.
- instr_done is high in MEMWB, MEMWRITE, ALUWB and BEQ, gated by the same wait condition as the state exit.

## Timing
- Outputs are purely combinational from the state register, plus Zero, op, funct3/7 and mem_ready. There is no output register.
- While reset=1, PCWrite, IRWrite, MemWrite, RegWrite, mem_req and instr_done are forced 0.
- On the first edge with reset=1, state←FETCH. After reset deasserts, outputs equal the FETCH decode and illegal=0.
- Reset asserted in any state, including mid-wait or ILLEGAL, returns to FETCH on the next edge. No write strobe is issued in the reset cycle.
- Cycles per instruction with zero wait states: lw 5, sw 4, R 4, I 4, beq 3, jal 4.
- op, funct3 and funct7 are sampled only from DECODE onward. The IR is stable then because IRWrite is asserted only in FETCH.

## Configuration
- MEM_WAIT_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold while mem_ready=0, keeping mem_req, AdrSrc and MemWrite asserted.
  - IRWrite and PCWrite in FETCH, and instr_done in MEMWRITE, are asserted only in the cycle mem_ready=1.
  - The state advances on that same edge.
- MEM_WAIT_EN undefined: mem_ready is ignored, and every memory state lasts exactly one cycle.

## Test plan
- Reset held 2 cycles, then released → state FETCH, IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, illegal=0. No strobe during reset.
- lw (op 0000011) → FETCH, DECODE, MEMADR (ImmSrc=00), MEMREAD (AdrSrc=1), MEMWB (RegWrite=1, ResultSrc=01, instr_done=1), back to FETCH. Total 5 cycles.
- R-type sub (op 0110011, funct3 000, funct7 1) → EXECR ALUControl=001. Same fields with op 0010011 → EXECI ALUControl=000.
- beq with Zero=1 → PCWrite=1 in BEQ. With Zero=0 → PCWrite=0. Both return to FETCH after 3 cycles.
- op 1111111 → ILLEGAL, illegal=1, all enables 0 for 10 cycles; reset → FETCH.
- With MEM_WAIT_EN, sw with mem_ready low for 3 cycles in MEMWRITE → MemWrite=1 for 4 cycles, instr_done only on the 4th, then FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RV32I core: drives every datapath select/enable per state.
// Optional MEM_WAIT_EN: memory states stall until mem_ready; otherwise mem_ready is ignored.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       mem_req,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
        StExecR, StExecI, StAluWb, StBeq, StJal, StIllegal
    } state_e;

    state_e     state_q, state_d;
    logic       mem_go;
    logic [2:0] alu_dec;

`ifdef MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_go = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // funct7 only selects sub for register-register ops; addi never subtracts.
    always_comb begin
        alu_dec = 3'b000;
        case (funct3)
            3'b000:  alu_dec = (funct7 & op[5]) ? 3'b001 : 3'b000;
            3'b010:  alu_dec = 3'b101;
            3'b110:  alu_dec = 3'b011;
            3'b111:  alu_dec = 3'b010;
            default: alu_dec = 3'b000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        mem_req    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = 3'b000;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                IRWrite   = mem_go;
                PCWrite   = mem_go;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_go) state_d = StDecode;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
                case (op)
                    7'b0000011, 7'b0100011: state_d = StMemAdr;
                    7'b0110011:             state_d = StExecR;
                    7'b0010011:             state_d = StExecI;
                    7'b1100011:             state_d = StBeq;
                    7'b1101111:             state_d = StJal;
                    default:                state_d = StIllegal;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = op[5] ? 2'b01 : 2'b00;
                state_d = op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_go) state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req    = 1'b1;
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_go;
                if (mem_go) state_d = StFetch;
            end
            StExecR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = alu_dec;
                state_d    = StAluWb;
            end
            StExecI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b00;
                ALUControl = alu_dec;
                state_d    = StAluWb;
            end
            StAluWb: begin
                ResultSrc  = 2'b00;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBeq: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = 3'b001;
                PCWrite    = Zero;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJal: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ImmSrc  = 2'b11;
                PCWrite = 1'b1;
                state_d = StAluWb;
            end
            StIllegal: begin
                illegal = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        // No architectural side effect may escape during the reset cycle.
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            mem_req    = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller, plus hand sequences for illegal, reset and waits.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, mem_req, RegWrite, instr_done, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [18:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct3    (funct3),
        .funct7    (funct7),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .mem_req   (mem_req),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ImmSrc    (ImmSrc),
        .ALUControl(ALUControl),
        .RegWrite  (RegWrite),
        .instr_done(instr_done),
        .illegal   (illegal)
    );

    // {PCWrite, AdrSrc, MemWrite, IRWrite, mem_req, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
    //  ALUControl, RegWrite, instr_done, illegal}
    assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, mem_req, ResultSrc, ALUSrcA, ALUSrcB,
                   ImmSrc, ALUControl, RegWrite, instr_done, illegal};

    localparam logic [18:0] MaskAll     = '1;
    localparam logic [18:0] MaskStrobe  = {5'b10111, 11'b0, 3'b110};
    localparam logic [18:0] ExpRst      = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] ExpFetch    = {5'b10011, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] ExpDecode   = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 3'b000};
    localparam logic [18:0] ExpAdrLd    = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] ExpAdrSt    = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 3'b000};
    localparam logic [18:0] ExpMemRead  = {5'b01001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] ExpMemWb    = {5'b00000, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 3'b110};
    localparam logic [18:0] ExpMemWrite = {5'b01101, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b010};
    localparam logic [18:0] ExpRSub     = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 3'b000};
    localparam logic [18:0] ExpIAdd     = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] ExpRSlt     = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b101, 3'b000};
    localparam logic [18:0] ExpIOr      = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011, 3'b000};
    localparam logic [18:0] ExpRAnd     = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010, 3'b000};
    localparam logic [18:0] ExpAluWb    = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b110};
    localparam logic [18:0] ExpBeqT     = {5'b10000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 3'b010};
    localparam logic [18:0] ExpBeqNt    = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 3'b010};
    localparam logic [18:0] ExpJal      = {5'b10000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 3'b000};
    localparam logic [18:0] ExpIll      = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001};
    localparam logic [18:0] ExpMwRst    = {5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] ExpFetchW   = {5'b00001, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] ExpMemWrW   = {5'b01101, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};

    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpBeq = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;
    localparam logic [6:0] OpBad = 7'b1111111;

    typedef struct packed {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        zero;
        logic        rdy;
        logic [18:0] exp;
        logic [18:0] mask;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [6:0] o, input logic [2:0] f3,
                                input logic f7, input logic z, input logic rdy,
                                input logic [18:0] e, input logic [18:0] m);
        vec_t v;
        v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7; v.zero = z; v.rdy = rdy;
        v.exp = e; v.mask = m;
        return v;
    endfunction

    // Drive one cycle's inputs at the falling edge, then check outputs before the next rise.
    task automatic run_vec(input vec_t v, input string name);
        @(negedge clk);
        reset = v.rst; op = v.op; funct3 = v.f3; funct7 = v.f7; Zero = v.zero;
        mem_ready = v.rdy;
        #1;
        n_tests++;
        if (((outs ^ v.exp) & v.mask) != 19'd0) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (mask %b)", name, outs, v.exp, v.mask);
        end
    endtask

    initial begin
        // Reset, then lw/sw/R/I/beq/jal walked cycle by cycle.
        tbl.push_back(mk(1, OpLw, 3'b000, 0, 0, 1, ExpRst,      MaskStrobe));
        tbl.push_back(mk(1, OpLw, 3'b000, 0, 0, 1, ExpRst,      MaskAll));
        tbl.push_back(mk(0, OpLw, 3'b000, 0, 0, 1, ExpFetch,    MaskAll));
        tbl.push_back(mk(0, OpLw, 3'b000, 0, 0, 1, ExpDecode,   MaskAll));
        tbl.push_back(mk(0, OpLw, 3'b000, 0, 0, 1, ExpAdrLd,    MaskAll));
        tbl.push_back(mk(0, OpLw, 3'b000, 0, 0, 1, ExpMemRead,  MaskAll));
        tbl.push_back(mk(0, OpLw, 3'b000, 0, 0, 1, ExpMemWb,    MaskAll));
        tbl.push_back(mk(0, OpSw, 3'b010, 0, 0, 1, ExpFetch,    MaskAll));
        tbl.push_back(mk(0, OpSw, 3'b010, 0, 0, 1, ExpDecode,   MaskAll));
        tbl.push_back(mk(0, OpSw, 3'b010, 0, 0, 1, ExpAdrSt,    MaskAll));
        tbl.push_back(mk(0, OpSw, 3'b010, 0, 0, 1, ExpMemWrite, MaskAll));
        tbl.push_back(mk(0, OpR,  3'b000, 1, 0, 1, ExpFetch,    MaskAll));
        tbl.push_back(mk(0, OpR,  3'b000, 1, 0, 1, ExpDecode,   MaskAll));
        tbl.push_back(mk(0, OpR,  3'b000, 1, 0, 1, ExpRSub,     MaskAll));
        tbl.push_back(mk(0, OpR,  3'b000, 1, 0, 1, ExpAluWb,    MaskAll));
        tbl.push_back(mk(0, OpI,  3'b000, 1, 0, 1, ExpFetch,    MaskAll));
        tbl.push_back(mk(0, OpI,  3'b000, 1, 0, 1, ExpDecode,   MaskAll));
        tbl.push_back(mk(0, OpI,  3'b000, 1, 0, 1, ExpIAdd,     MaskAll));
        tbl.push_back(mk(0, OpI,  3'b000, 1, 0, 1, ExpAluWb,    MaskAll));
        tbl.push_back(mk(0, OpR,  3'b010, 0, 0, 1, ExpFetch,    MaskAll));
        tbl.push_back(mk(0, OpR,  3'b010, 0, 0, 1, ExpDecode,   MaskAll));
        tbl.push_back(mk(0, OpR,  3'b010, 0, 0, 1, ExpRSlt,     MaskAll));
        tbl.push_back(mk(0, OpR,  3'b010, 0, 0, 1, ExpAluWb,    MaskAll));
        tbl.push_back(mk(0, OpBeq, 3'b000, 0, 1, 1, ExpFetch,   MaskAll));
        tbl.push_back(mk(0, OpBeq, 3'b000, 0, 1, 1, ExpDecode,  MaskAll));
        tbl.push_back(mk(0, OpBeq, 3'b000, 0, 1, 1, ExpBeqT,    MaskAll));
        tbl.push_back(mk(0, OpBeq, 3'b000, 0, 0, 1, ExpFetch,   MaskAll));
        tbl.push_back(mk(0, OpBeq, 3'b000, 0, 0, 1, ExpDecode,  MaskAll));
        tbl.push_back(mk(0, OpBeq, 3'b000, 0, 0, 1, ExpBeqNt,   MaskAll));
        tbl.push_back(mk(0, OpJal, 3'b000, 0, 0, 1, ExpFetch,   MaskAll));
        tbl.push_back(mk(0, OpJal, 3'b000, 0, 0, 1, ExpDecode,  MaskAll));
        tbl.push_back(mk(0, OpJal, 3'b000, 0, 0, 1, ExpJal,     MaskAll));
        tbl.push_back(mk(0, OpJal, 3'b000, 0, 0, 1, ExpAluWb,   MaskAll));
        tbl.push_back(mk(0, OpI,  3'b110, 0, 0, 1, ExpFetch,    MaskAll));
        tbl.push_back(mk(0, OpI,  3'b110, 0, 0, 1, ExpDecode,   MaskAll));
        tbl.push_back(mk(0, OpI,  3'b110, 0, 0, 1, ExpIOr,      MaskAll));
        tbl.push_back(mk(0, OpI,  3'b110, 0, 0, 1, ExpAluWb,    MaskAll));
        tbl.push_back(mk(0, OpR,  3'b111, 0, 0, 1, ExpFetch,    MaskAll));
        tbl.push_back(mk(0, OpR,  3'b111, 0, 0, 1, ExpDecode,   MaskAll));
        tbl.push_back(mk(0, OpR,  3'b111, 0, 0, 1, ExpRAnd,     MaskAll));
        tbl.push_back(mk(0, OpR,  3'b111, 0, 0, 1, ExpAluWb,    MaskAll));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Unsupported opcode halts until reset; reset in ILLEGAL issues no strobe.
        run_vec(mk(0, OpBad, 3'b000, 0, 0, 1, ExpFetch,  MaskAll), "ill_fetch");
        run_vec(mk(0, OpBad, 3'b000, 0, 0, 1, ExpDecode, MaskAll), "ill_decode");
        for (int i = 0; i < 10; i++) begin
            run_vec(mk(0, OpBad, 3'b000, 0, 1, 1, ExpIll, MaskAll), $sformatf("ill_hold%0d", i));
        end
        run_vec(mk(1, OpBad, 3'b000, 0, 0, 1, ExpIll,   MaskAll), "ill_reset");
        run_vec(mk(0, OpSw,  3'b000, 0, 0, 1, ExpFetch, MaskAll), "ill_recover");

        // Reset landing in MEMWRITE suppresses MemWrite, mem_req and instr_done.
        run_vec(mk(0, OpSw, 3'b000, 0, 0, 1, ExpDecode, MaskAll), "rst_mw_decode");
        run_vec(mk(0, OpSw, 3'b000, 0, 0, 1, ExpAdrSt,  MaskAll), "rst_mw_adr");
        run_vec(mk(1, OpSw, 3'b000, 0, 0, 1, ExpMwRst,  MaskAll), "rst_mw_write");
        run_vec(mk(0, OpSw, 3'b000, 0, 0, 1, ExpFetch,  MaskAll), "rst_mw_fetch");
        run_vec(mk(0, OpSw, 3'b000, 0, 0, 1, ExpDecode, MaskAll), "sw2_decode");
        run_vec(mk(0, OpSw, 3'b000, 0, 0, 1, ExpAdrSt,  MaskAll), "sw2_adr");

`ifdef MEM_WAIT_EN
        // sw stalled 3 cycles in MEMWRITE, then an instruction fetch stalled 2 cycles.
        for (int i = 0; i < 3; i++) begin
            run_vec(mk(0, OpSw, 3'b000, 0, 0, 0, ExpMemWrW, MaskAll), $sformatf("mw_wait%0d", i));
        end
        run_vec(mk(0, OpSw, 3'b000, 0, 0, 1, ExpMemWrite, MaskAll), "mw_done");
        for (int i = 0; i < 2; i++) begin
            run_vec(mk(0, OpSw, 3'b000, 0, 0, 0, ExpFetchW, MaskAll), $sformatf("fetch_wait%0d", i));
        end
        run_vec(mk(0, OpSw, 3'b000, 0, 0, 1, ExpFetch,  MaskAll), "fetch_go");
        run_vec(mk(0, OpSw, 3'b000, 0, 0, 1, ExpDecode, MaskAll), "fetch_go_decode");
`else
        // mem_ready low is ignored: MEMWRITE and FETCH each last one cycle.
        run_vec(mk(0, OpSw, 3'b000, 0, 0, 0, ExpMemWrite, MaskAll), "nowait_mw");
        run_vec(mk(0, OpSw, 3'b000, 0, 0, 0, ExpFetch,    MaskAll), "nowait_fetch");
        run_vec(mk(0, OpSw, 3'b000, 0, 0, 0, ExpDecode,   MaskAll), "nowait_decode");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
